// File: rtl/slt_serial_if.sv
// Request/result bundle for the bit-serial set-less-than unit.
// SLT_SERIAL_UNSIGNED_EN adds the is_unsigned request bit.
interface slt_serial_if #(
  parameter int n = 32
);
  logic         start;
  logic [n-1:0] r2;
  logic [n-1:0] r3;
  logic         busy;
  logic         done;
  logic [n-1:0] r1;
`ifdef SLT_SERIAL_UNSIGNED_EN
  logic         is_unsigned;

  modport master (output start, r2, r3, is_unsigned, input busy, done, r1);
  modport slave  (input start, r2, r3, is_unsigned, output busy, done, r1);
`else
  modport master (output start, r2, r3, input busy, done, r1);
  modport slave  (input start, r2, r3, output busy, done, r1);
`endif
endinterface

// File: rtl/slt_serial.sv
// Bit-serial set-less-than: computes r2 - r3 LSB first, one bit per clock, and reports lt.
// Optional macro SLT_SERIAL_UNSIGNED_EN adds an unsigned (SLTU) mode selected per request.
module slt_serial #(
  parameter int n = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  slt_serial_if.slave bus
);
  localparam int CW = $clog2(n);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_reg, state_next;
  logic [n-1:0]   a_reg, a_next;
  logic [n-1:0]   b_reg, b_next;
  logic           carry_reg, carry_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [n-1:0]   r1_reg, r1_next;
  logic           a_bit, b_bit, d_bit, cout;
  logic           lt_signed, lt;
`ifdef SLT_SERIAL_UNSIGNED_EN
  logic           uns_reg, uns_next;
`endif

  // One full-adder slice of a + ~b + carry, i.e. a - b with carry-in 1 at bit 0.
  assign a_bit     = a_reg[0];
  assign b_bit     = ~b_reg[0];
  assign d_bit     = a_bit ^ b_bit ^ carry_reg;
  assign cout      = (a_bit & b_bit) | (a_bit & carry_reg) | (b_bit & carry_reg);
  // At the MSB, carry-in xor carry-out is the signed overflow flag.
  assign lt_signed = d_bit ^ (carry_reg ^ cout);
`ifdef SLT_SERIAL_UNSIGNED_EN
  assign lt        = uns_reg ? ~cout : lt_signed;
`else
  assign lt        = lt_signed;
`endif

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    carry_next = carry_reg;
    cnt_next   = cnt_reg;
    r1_next    = r1_reg;
`ifdef SLT_SERIAL_UNSIGNED_EN
    uns_next   = uns_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          a_next     = bus.r2;
          b_next     = bus.r3;
          carry_next = 1'b1;
          cnt_next   = '0;
`ifdef SLT_SERIAL_UNSIGNED_EN
          uns_next   = bus.is_unsigned;
`endif
          state_next = RUN;
        end
      end
      RUN: begin
        a_next     = a_reg >> 1;
        b_next     = b_reg >> 1;
        carry_next = cout;
        cnt_next   = cnt_reg + CW'(1);
        if (cnt_reg == CW'(n - 1)) begin
          r1_next    = {{(n-1){1'b0}}, lt};
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b1;
      cnt_reg   <= '0;
      r1_reg    <= '0;
`ifdef SLT_SERIAL_UNSIGNED_EN
      uns_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      carry_reg <= carry_next;
      cnt_reg   <= cnt_next;
      r1_reg    <= r1_next;
`ifdef SLT_SERIAL_UNSIGNED_EN
      uns_reg   <= uns_next;
`endif
    end
  end

  assign bus.busy = (state_reg == RUN);
  assign bus.done = (state_reg == DONE);
  assign bus.r1   = r1_reg;
endmodule

// File: doc/slt_serial.md
Name: slt_serial

Overview:
- Bit-serial, multi-cycle counterpart of the parallel set-less-than unit.
- Latches two signed n-bit operands on a start handshake, then performs r2 − r3 one bit per clock, LSB first, with a 1-bit carry.
- Reports r1 = 1 if r2 < r3 (signed), else 0, with a done pulse.
- Used in area-constrained datapaths where the parallel comparator is too large; result format is identical to the parallel unit.

Parameters:
- n, 32, operand and result width in bits (n ≥ 2).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- r2  input  n  signed left operand; sampled on the accepted-start edge.
- r3  input  n  signed right operand; sampled on the accepted-start edge.
- busy  output  1  high while a comparison is in progress (RUN).
- done  output  1  one-cycle pulse; r1 valid and updated in this cycle.
- r1  output  n  result {(n-1)'b0, lt}; held until the next done.

Behaviour:
- Clocking/reset: one clock. Reset is synchronous, active-low: rst_n=0 at a rising edge forces state=IDLE, busy=0, done=0, r1=0, counter=0, carry=1, and clears the shift registers. Applies even mid-RUN: the operation is aborted and no done follows.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 at an edge: load A←r2, B←r3, carry←1, cnt←0; go to RUN.
  - start=0: stay in IDLE.
- RUN:
  - busy=1. Each edge: a=A[0], b=~B[0], d=a^b^carry, cout=(a&b)|(a&carry)|(b&carry).
  - Shift A and B right by 1; carry←cout; cnt←cnt+1.
  - At cnt==n-1 (MSB bit): lt_s = d ^ (carry ^ cout), i.e. sign XOR overflow. Store lt; go to DONE.
  - start is ignored. r2/r3 changes during RUN have no effect.
- DONE:
  - busy=0, done=1 for exactly one cycle; r1={(n-1)'b0, lt} is updated at entry to DONE.
  - Next edge: go to IDLE unconditionally. start in DONE is ignored; the earliest re-issue is the cycle after done.
- Latency: start sampled at edge k → RUN edges k+1..k+n → done high during cycle after edge k+n (n+1 edges after accept).
- Throughput: one result per n+2 cycles.
- Arithmetic: two's complement. The overflow correction makes the result exact across the full range, e.g. 0x7fffffff vs 0x80000001 gives lt=0.
- Equal operands give lt=0.
- cnt width: clog2(n).
- r1 upper bits are always 0.

Optional Feature:
- Macro: SLT_SERIAL_UNSIGNED_EN.
- Defined:
  - Adds input port is_unsigned (1 bit), latched together with r2/r3.
  - If the latched value is 1, lt = ~cout at the MSB step (borrow out), giving the SLTU result.
  - If 0, signed behaviour as above.
- Undefined: the port does not exist and the unit is signed-only. Logic is identical to is_unsigned=0.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, start=0 → busy=0, done=0, r1=0; no done ever.
- Basic signed, n=32: r2=0xffffffff, r3=5, start pulse → busy high 32 cycles, done 33 cycles after accept, r1=1. Then r2=37, r3=25 → r1=0. Then r2=25, r3=25 → r1=0.
- Overflow boundary: r2=0x7fffffff, r3=0x80000001 → r1=0. Then r2=0x80000000, r3=0x7fffffff → r1=1. Then r2=0xfffffffe, r3=0xffffffff → r1=1.
- Operand and start isolation: start and new r2/r3 toggled during RUN and in the DONE cycle → result reflects the latched operands; only one done per accepted start.
- Reset mid-operation: rst_n=0 at RUN cycle 10 → next cycle busy=0, r1=0, no done. A fresh start with r2=0, r3=2 → r1=1 after n+1 cycles.
- With SLT_SERIAL_UNSIGNED_EN: is_unsigned=1, r2=5, r3=0xffffffff → r1=1. is_unsigned=0, same operands → r1=0.
